// File: rtl/bomb_pool_ctrl.sv
// rtl/bomb_pool_ctrl.sv - bomb slot manager: ammo capacity, fuse/blast timers, chain reactions
module bomb_pool_ctrl #(
    parameter int NUM_SLOTS    = 3,
    parameter int MAX_BOMBS    = 3,
    parameter int START_BOMBS  = 2,
    parameter int FUSE_SEC     = 3,
    parameter int BLAST_FRAMES = 30,
    parameter int TILE_LOG2    = 5,
    parameter int CHAIN_EN     = 1,
    localparam int TW          = 11 - TILE_LOG2
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   OneSecPulse,
    input  logic                   startOfFrame,
    input  logic                   drop_bomb_key,
    input  logic [10:0]            player_topLeftX,
    input  logic [10:0]            player_topLeftY,
    input  logic [2:0]             blast_num,
    input  logic                   inc_bomb,
    input  logic                   score_reset,
    output logic [NUM_SLOTS-1:0]   slot_armed,
    output logic [NUM_SLOTS-1:0]   slot_blasting,
    output logic [NUM_SLOTS*TW-1:0] slot_tileX,
    output logic [NUM_SLOTS*TW-1:0] slot_tileY,
    output logic [NUM_SLOTS*3-1:0] slot_radius,
    output logic [3:0]             bombs_left,
    output logic                   blast,
    output logic                   explosion,
    output logic                   drop_rejected
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BLAST} slot_state_e;

    localparam logic [11:0] HALF_TILE = 12'(1) << (TILE_LOG2 - 1);

    slot_state_e   state_q [NUM_SLOTS];
    slot_state_e   state_d [NUM_SLOTS];
    logic [3:0]    fuse_q  [NUM_SLOTS];
    logic [3:0]    fuse_d  [NUM_SLOTS];
    logic [7:0]    bcnt_q  [NUM_SLOTS];
    logic [7:0]    bcnt_d  [NUM_SLOTS];
    logic [TW-1:0] tx_q    [NUM_SLOTS];
    logic [TW-1:0] tx_d    [NUM_SLOTS];
    logic [TW-1:0] ty_q    [NUM_SLOTS];
    logic [TW-1:0] ty_d    [NUM_SLOTS];
    logic [2:0]    rad_q   [NUM_SLOTS];
    logic [2:0]    rad_d   [NUM_SLOTS];
    logic [3:0]    cap_q, cap_d;
    logic          key_q, key_d;
    logic          req_q, req_d;
    logic          blast_q, blast_d;
    logic          rej_q, rej_d;

    logic [11:0]    sum_x, sum_y;
    logic [10:0]    cen_x, cen_y;
    logic [TW-1:0]  new_tx, new_ty;
    logic [2:0]     new_rad;
    logic [3:0]     busy;
    logic           free_found, clash, accept;
    logic [2:0]     free_idx;
    logic [NUM_SLOTS-1:0] chain_hit;

    function automatic logic [TW-1:0] abs_diff(input logic [TW-1:0] a, input logic [TW-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // Tile of the player's centre; the add saturates so the tile never wraps to 0.
    always_comb begin
        sum_x   = {1'b0, player_topLeftX} + HALF_TILE;
        sum_y   = {1'b0, player_topLeftY} + HALF_TILE;
        cen_x   = sum_x[11] ? 11'h7FF : sum_x[10:0];
        cen_y   = sum_y[11] ? 11'h7FF : sum_y[10:0];
        new_tx  = TW'(cen_x >> TILE_LOG2);
        new_ty  = TW'(cen_y >> TILE_LOG2);
        new_rad = (blast_num == 3'd0) ? 3'd1 : blast_num;
    end

    always_comb begin
        busy       = 4'd0;
        free_found = 1'b0;
        free_idx   = 3'd0;
        clash      = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (state_q[i] == S_IDLE) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end else begin
                busy = busy + 4'd1;
                if (tx_q[i] == new_tx && ty_q[i] == new_ty)
                    clash = 1'b1;
            end
        end
        bombs_left = (busy > cap_q) ? 4'd0 : cap_q - busy;
        accept     = req_q && (bombs_left != 4'd0) && free_found && !clash;
    end

    always_comb begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
            chain_hit[j] = 1'b0;
            if (CHAIN_EN != 0 && state_q[j] == S_ARMED) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (state_q[i] == S_BLAST &&
                        ((ty_q[j] == ty_q[i] && abs_diff(tx_q[j], tx_q[i]) <= TW'(rad_q[i])) ||
                         (tx_q[j] == tx_q[i] && abs_diff(ty_q[j], ty_q[i]) <= TW'(rad_q[i]))))
                        chain_hit[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        key_d   = drop_bomb_key;
        req_d   = drop_bomb_key && !key_q;
        rej_d   = req_q && !accept;
        blast_d = 1'b0;
        cap_d   = (inc_bomb && cap_q < 4'(MAX_BOMBS)) ? cap_q + 4'd1 : cap_q;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            state_d[j] = state_q[j];
            fuse_d[j]  = fuse_q[j];
            bcnt_d[j]  = bcnt_q[j];
            tx_d[j]    = tx_q[j];
            ty_d[j]    = ty_q[j];
            rad_d[j]   = rad_q[j];
            case (state_q[j])
                S_IDLE: begin
                    if (accept && free_idx == 3'(j)) begin
                        state_d[j] = S_ARMED;
                        fuse_d[j]  = 4'(FUSE_SEC);
                        tx_d[j]    = new_tx;
                        ty_d[j]    = new_ty;
                        rad_d[j]   = new_rad;
                    end
                end
                S_ARMED: begin
                    if (chain_hit[j] || (OneSecPulse && fuse_q[j] == 4'd1)) begin
                        state_d[j] = S_BLAST;
                        bcnt_d[j]  = 8'(BLAST_FRAMES);
                        blast_d    = 1'b1;
                    end else if (OneSecPulse) begin
                        fuse_d[j] = fuse_q[j] - 4'd1;
                    end
                end
                S_BLAST: begin
                    if (startOfFrame) begin
                        if (bcnt_q[j] == 8'd1)
                            state_d[j] = S_IDLE;
                        else
                            bcnt_d[j] = bcnt_q[j] - 8'd1;
                    end
                end
                default: state_d[j] = S_IDLE;
            endcase
        end
        if (score_reset) begin
            key_d   = 1'b0;
            req_d   = 1'b0;
            rej_d   = 1'b0;
            blast_d = 1'b0;
            cap_d   = 4'(START_BOMBS);
            for (int j = 0; j < NUM_SLOTS; j++) begin
                state_d[j] = S_IDLE;
                fuse_d[j]  = 4'd0;
                bcnt_d[j]  = 8'd0;
                tx_d[j]    = '0;
                ty_d[j]    = '0;
                rad_d[j]   = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_q   <= 1'b0;
            req_q   <= 1'b0;
            rej_q   <= 1'b0;
            blast_q <= 1'b0;
            cap_q   <= 4'(START_BOMBS);
            for (int j = 0; j < NUM_SLOTS; j++) begin
                state_q[j] <= S_IDLE;
                fuse_q[j]  <= 4'd0;
                bcnt_q[j]  <= 8'd0;
                tx_q[j]    <= '0;
                ty_q[j]    <= '0;
                rad_q[j]   <= 3'd0;
            end
        end else begin
            key_q   <= key_d;
            req_q   <= req_d;
            rej_q   <= rej_d;
            blast_q <= blast_d;
            cap_q   <= cap_d;
            for (int j = 0; j < NUM_SLOTS; j++) begin
                state_q[j] <= state_d[j];
                fuse_q[j]  <= fuse_d[j];
                bcnt_q[j]  <= bcnt_d[j];
                tx_q[j]    <= tx_d[j];
                ty_q[j]    <= ty_d[j];
                rad_q[j]   <= rad_d[j];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
            slot_armed[j]          = (state_q[j] == S_ARMED);
            slot_blasting[j]       = (state_q[j] == S_BLAST);
            slot_tileX[j*TW +: TW] = tx_q[j];
            slot_tileY[j*TW +: TW] = ty_q[j];
            slot_radius[j*3 +: 3]  = rad_q[j];
        end
        explosion     = |slot_blasting;
        blast         = blast_q;
        drop_rejected = rej_q;
    end
endmodule

// File: tb/tb_bomb_pool_ctrl.sv
// tb/tb_bomb_pool_ctrl.sv - directed self-checking bench for bomb_pool_ctrl
module tb_bomb_pool_ctrl;
    logic        clk = 1'b0;
    logic        resetN, OneSecPulse, startOfFrame, drop_bomb_key, inc_bomb, score_reset;
    logic [10:0] player_topLeftX, player_topLeftY;
    logic [2:0]  blast_num;
    logic [2:0]  slot_armed, slot_blasting;
    logic [17:0] slot_tileX, slot_tileY;
    logic [8:0]  slot_radius;
    logic [3:0]  bombs_left;
    logic        blast, explosion, drop_rejected;

    int errors = 0;
    int checks = 0;
    int cnt;

    bomb_pool_ctrl dut (
        .clk(clk), .resetN(resetN), .OneSecPulse(OneSecPulse), .startOfFrame(startOfFrame),
        .drop_bomb_key(drop_bomb_key), .player_topLeftX(player_topLeftX),
        .player_topLeftY(player_topLeftY), .blast_num(blast_num), .inc_bomb(inc_bomb),
        .score_reset(score_reset), .slot_armed(slot_armed), .slot_blasting(slot_blasting),
        .slot_tileX(slot_tileX), .slot_tileY(slot_tileY), .slot_radius(slot_radius),
        .bombs_left(bombs_left), .blast(blast), .explosion(explosion),
        .drop_rejected(drop_rejected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int x, input int y);
        player_topLeftX = 11'(x);
        player_topLeftY = 11'(y);
        drop_bomb_key = 1'b0;
        step();
        drop_bomb_key = 1'b1;
        step();
        step();
        drop_bomb_key = 1'b0;
    endtask

    task automatic sec_pulse();
        OneSecPulse = 1'b1;
        step();
        OneSecPulse = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; OneSecPulse = 1'b0; startOfFrame = 1'b0; drop_bomb_key = 1'b0;
        inc_bomb = 1'b0; score_reset = 1'b0; blast_num = 3'd2;
        player_topLeftX = 11'd0; player_topLeftY = 11'd0;
        repeat (3) step();
        resetN = 1'b1;
        step();
        check("rst_bombs_left", 32'(bombs_left), 2);
        check("rst_armed", 32'(slot_armed), 0);
        check("rst_blast", 32'(blast), 0);

        // 1: first drop at (100,68) -> tile (3,2)
        player_topLeftX = 11'd100; player_topLeftY = 11'd68;
        drop_bomb_key = 1'b1;
        step(); step();
        check("t1_armed", 32'(slot_armed), 32'b001);
        check("t1_tileX", 32'(slot_tileX[5:0]), 3);
        check("t1_tileY", 32'(slot_tileY[5:0]), 2);
        check("t1_radius", 32'(slot_radius[2:0]), 2);
        check("t1_bombs_left", 32'(bombs_left), 1);

        // 2: holding the key repeats nothing; re-press on same tile is refused
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt += int'(drop_rejected) + (slot_armed != 3'b001 ? 1 : 0);
        end
        check("t2_hold_quiet", 32'(cnt), 0);
        drop(100, 68);
        check("t2_rejected", 32'(drop_rejected), 1);
        check("t2_one_slot", 32'(slot_armed), 32'b001);
        step();
        check("t2_rej_pulse_end", 32'(drop_rejected), 0);

        // 3: fuse expiry then full blast window
        sec_pulse(); sec_pulse();
        check("t3_still_armed", 32'(slot_armed), 32'b001);
        sec_pulse();
        check("t3_blasting", 32'(slot_blasting), 32'b001);
        check("t3_blast_pulse", 32'(blast), 1);
        check("t3_explosion", 32'(explosion), 1);
        step();
        check("t3_blast_end", 32'(blast), 0);
        for (int i = 0; i < 29; i++) begin
            startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        end
        check("t3_blast_29", 32'(slot_blasting), 32'b001);
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        check("t3_idle", 32'(slot_blasting | slot_armed), 0);
        check("t3_bombs_left", 32'(bombs_left), 2);

        // 4: chain reaction from tile (3,2) to (5,2) with radius 2
        drop(100, 68);
        sec_pulse();
        drop(150, 68);
        check("t4_tileX1", 32'(slot_tileX[11:6]), 5);
        check("t4_armed", 32'(slot_armed), 32'b011);
        check("t4_bombs_left", 32'(bombs_left), 0);
        sec_pulse(); sec_pulse();
        check("t4_first_blast", 32'(slot_blasting), 32'b001);
        check("t4_first_pulse", 32'(blast), 1);
        step();
        check("t4_chain_blast", 32'(slot_blasting), 32'b011);
        check("t4_chain_pulse", 32'(blast), 1);
        step();
        check("t4_pulse_end", 32'(blast), 0);
        for (int i = 0; i < 30; i++) begin
            startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        end
        check("t4_idle", 32'(slot_blasting | slot_armed), 0);
        check("t4_bombs_left", 32'(bombs_left), 2);

        // 5: capacity saturates at 3; a fourth drop is refused
        for (int i = 0; i < 3; i++) begin
            inc_bomb = 1'b1; step(); inc_bomb = 1'b0;
        end
        check("t5_cap_sat", 32'(bombs_left), 3);
        drop(100, 68);
        drop(150, 68);
        blast_num = 3'd0;
        drop(200, 68);
        check("t5_radius_min", 32'(slot_radius[8:6]), 1);
        check("t5_tileX2", 32'(slot_tileX[17:12]), 6);
        check("t5_full", 32'(slot_armed), 32'b111);
        check("t5_bombs_left", 32'(bombs_left), 0);
        blast_num = 3'd2;
        drop(250, 68);
        check("t5_rejected", 32'(drop_rejected), 1);
        check("t5_no_change", 32'(slot_armed), 32'b111);

        // 6: score_reset during blast discards everything without a pulse
        sec_pulse(); sec_pulse(); sec_pulse();
        check("t6_all_blast", 32'(slot_blasting), 32'b111);
        step();
        for (int i = 0; i < 5; i++) begin
            startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        end
        score_reset = 1'b1; step(); score_reset = 1'b0;
        check("t6_idle", 32'(slot_blasting | slot_armed), 0);
        check("t6_bombs_left", 32'(bombs_left), 2);
        check("t6_explosion", 32'(explosion), 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt += int'(blast);
            step();
        end
        check("t6_no_blast", 32'(cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
